// File: rtl/conv_output_writer_pkg.sv
// Shared constants for the convolution layer blocks: default geometry,
// output-writer FSM encoding and derived output dimensions.
package conv_output_writer_pkg;

  localparam int unsigned IMG_W_DEF  = 100;
  localparam int unsigned IMG_H_DEF  = 100;
  localparam int unsigned K_DEF      = 3;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W     = 14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int unsigned out_dim(input int unsigned img, input int unsigned k);
    return img - k + 1;
  endfunction

  // Bits needed to hold the values 0..n-1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned OUT_W_DEF = out_dim(IMG_W_DEF, K_DEF);
  localparam int unsigned OUT_H_DEF = out_dim(IMG_H_DEF, K_DEF);

endpackage

// File: rtl/conv_output_writer_pos_counter.sv
// Column/row position tracker for the input raster, with wrap and
// valid-window / last-pixel flags derived from the current position.
module conv_output_writer_pos_counter
  import conv_output_writer_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF,
  parameter int unsigned K     = K_DEF
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clear,
  input  logic advance,
  output logic in_window,
  output logic last_pos
);

  localparam int unsigned COL_W = cnt_w(IMG_W);
  localparam int unsigned ROW_W = cnt_w(IMG_H);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_WIN  = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] ROW_WIN  = ROW_W'(K - 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  always_ff @(posedge Clk) begin
    if (Rst || clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign in_window = (col >= COL_WIN) && (row >= ROW_WIN);
  assign last_pos  = (col == COL_LAST) && (row == ROW_LAST);

endmodule

// File: rtl/conv_output_writer.sv
// Writes in-window convolution results to the output feature map, row-major,
// with a one-cycle registered write port and a frame-complete pulse.
module conv_output_writer
  import conv_output_writer_pkg::*;
#(
  parameter int unsigned IMG_W  = IMG_W_DEF,
  parameter int unsigned IMG_H  = IMG_H_DEF,
  parameter int unsigned K      = K_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic              In_Valid,
  input  logic [DATA_W-1:0] In_Data,
  output logic              Wr_En,
  output logic [13:0]       Wr_Addr,
  output logic [DATA_W-1:0] Wr_Data,
  output logic              Busy,
  output logic              Done
);

  state_t state, state_nx;

  logic              start_frame;
  logic              pix_vld;
  logic              in_window;
  logic              last_pos;
  logic [ADDR_W-1:0] addr_cnt;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  assign start_frame = (state == ST_IDLE) && Start;
  assign pix_vld     = (state == ST_RUN) && In_Valid;

  conv_output_writer_pos_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .K     (K)
  ) u_pos (
    .Clk       (Clk),
    .Rst       (Rst),
    .clear     (start_frame),
    .advance   (pix_vld),
    .in_window (in_window),
    .last_pos  (last_pos)
  );

  always_ff @(posedge Clk) begin
    if (Rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (Start) state_nx = ST_RUN;
      ST_RUN:  if (In_Valid && last_pos) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // The final write is registered on the same edge that enters DONE,
  // so Done and the last Wr_En share a cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      addr_cnt  <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (start_frame) begin
        addr_cnt <= '0;
      end else if (pix_vld && in_window) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= addr_cnt;
        wr_data_q <= In_Data;
        addr_cnt  <= addr_cnt + 1'b1;
      end
    end
  end

  assign Wr_En   = wr_en_q;
  assign Wr_Addr = wr_addr_q;
  assign Wr_Data = wr_data_q;
  assign Busy    = (state == ST_RUN);
  assign Done    = (state == ST_DONE);

endmodule

// File: tb/tb_conv_output_writer.sv
// Randomized self-checking bench: a pixel-index model predicts every write,
// Busy and Done cycle by cycle, plus per-frame totals.
module tb_conv_output_writer;

  localparam int IMG_W  = 100;
  localparam int IMG_H  = 100;
  localparam int K      = 3;
  localparam int DATA_W = 32;
  localparam int OW     = IMG_W - K + 1;
  localparam int OH     = IMG_H - K + 1;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NOUT   = OW * OH;

  logic              Clk = 1'b0;
  logic              Rst = 1'b1;
  logic              Start = 1'b0;
  logic              In_Valid = 1'b0;
  logic [DATA_W-1:0] In_Data = '0;
  logic              Wr_En;
  logic [13:0]       Wr_Addr;
  logic [DATA_W-1:0] Wr_Data;
  logic              Busy;
  logic              Done;

  always #5 Clk = ~Clk;

  conv_output_writer #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .K      (K),
    .DATA_W (DATA_W)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Start    (Start),
    .In_Valid (In_Valid),
    .In_Data  (In_Data),
    .Wr_En    (Wr_En),
    .Wr_Addr  (Wr_Addr),
    .Wr_Data  (Wr_Data),
    .Busy     (Busy),
    .Done     (Done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame phase plus count of consumed pixels.
  typedef enum {M_IDLE, M_RUN, M_DONE} mphase_t;
  mphase_t     m_ph   = M_IDLE;
  int          m_pix  = 0;
  bit          m_wr   = 1'b0;
  logic [13:0] m_addr = '0;
  logic [31:0] m_data = '0;
  bit          mon_en = 1'b0;

  task automatic cyc(input bit rst, input bit st, input bit vld, input logic [31:0] d);
    int r, c;
    Rst = rst; Start = st; In_Valid = vld; In_Data = d;
    @(posedge Clk);
    m_wr = 1'b0;
    if (rst) begin
      m_ph = M_IDLE; m_pix = 0; m_addr = '0; m_data = '0;
    end else begin
      case (m_ph)
        M_IDLE: if (st) begin m_ph = M_RUN; m_pix = 0; end
        M_RUN: if (vld) begin
          r = m_pix / IMG_W;
          c = m_pix % IMG_W;
          if (r >= K - 1 && c >= K - 1) begin
            m_wr   = 1'b1;
            m_addr = 14'((r - (K - 1)) * OW + (c - (K - 1)));
            m_data = d;
          end
          m_pix++;
          if (m_pix == NPIX) m_ph = M_DONE;
        end
        M_DONE: m_ph = M_IDLE;
        default: m_ph = M_IDLE;
      endcase
    end
    #1;
  endtask

  int          n_wr = 0, n_done = 0;
  logic [13:0] first_addr, last_addr;
  logic [31:0] first_data, last_data;
  bit          done_with_wr;

  always @(negedge Clk) begin
    if (mon_en) begin
      chk("wr_en",   Wr_En,   m_wr);
      chk("wr_addr", Wr_Addr, m_addr);
      chk("wr_data", Wr_Data, m_data);
      chk("busy",    Busy,    m_ph == M_RUN);
      chk("done",    Done,    m_ph == M_DONE);
      if (Wr_En) begin
        if (n_wr == 0) begin first_addr = Wr_Addr; first_data = Wr_Data; end
        last_addr = Wr_Addr; last_data = Wr_Data;
        n_wr++;
      end
      if (Done) begin
        n_done++;
        done_with_wr = Wr_En;
      end
    end
  end

  task automatic clr_stats();
    n_wr = 0; n_done = 0; done_with_wr = 1'b0;
    first_addr = 'x; last_addr = 'x; first_data = 'x; last_data = 'x;
  endtask

  // mode 0: contiguous, data=index; 1: valid every third cycle, data=index,
  // stray Starts in gaps; 2: random gaps/data/Starts; 3: contiguous random data.
  task automatic run_frame(input int mode);
    int p;
    logic [31:0] d;
    cyc(0, 1, 0, 0);
    p = 0;
    while (p < NPIX) begin
      d = (mode <= 1) ? 32'(p) : $urandom;
      if (mode == 1) begin
        cyc(0, 1'($urandom_range(0, 1)), 0, $urandom);
        cyc(0, 1'($urandom_range(0, 1)), 0, $urandom);
        cyc(0, 0, 1, d);
        p++;
      end else if (mode == 2 && $urandom_range(0, 4) == 0) begin
        cyc(0, 1'($urandom_range(0, 1)), 0, $urandom);
      end else begin
        cyc(0, (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0, 1, d);
        p++;
      end
    end
  endtask

  task automatic chk_frame(input string tag, input bit idx_data);
    chk({tag, "_nwr"},     n_wr, NOUT);
    chk({tag, "_first_a"}, first_addr, 0);
    chk({tag, "_last_a"},  last_addr, NOUT - 1);
    chk({tag, "_ndone"},   n_done, 1);
    chk({tag, "_done_wr"}, done_with_wr, 1);
    if (idx_data) begin
      chk({tag, "_first_d"}, first_data, (K - 1) * IMG_W + (K - 1));
      chk({tag, "_last_d"},  last_data, NPIX - 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(1, 0, 0, 0);
    mon_en = 1'b1;
    cyc(1, 0, 0, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_wren", Wr_En, 0);

    // In_Valid noise while idle must not write or advance anything.
    clr_stats();
    repeat (20) cyc(0, 0, 1'($urandom_range(0, 1)), $urandom);
    chk("idle_nwr", n_wr, 0);

    // Contiguous frame; Start during DONE->IDLE must be ignored.
    clr_stats();
    run_frame(0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk_frame("f_contig", 1);
    chk("after_done_busy", Busy, 0);

    // Sparse In_Valid with Starts during RUN.
    clr_stats();
    run_frame(1);
    cyc(0, 0, 0, 0);
    chk_frame("f_sparse", 1);

    // Abort after 5000 pixels, then a random-gap frame.
    clr_stats();
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 5000; i++) cyc(0, 0, 1, $urandom);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("abort_ndone", n_done, 0);
    chk("abort_nwr", n_wr, (5000 / IMG_W - (K - 1)) * OW);
    clr_stats();
    run_frame(2);
    cyc(0, 0, 0, 0);
    chk_frame("f_after_abort", 0);

    // Back-to-back: Start in the cycle right after Done.
    clr_stats();
    run_frame(3);
    cyc(0, 0, 0, 0);
    chk_frame("f_b2b_a", 0);
    clr_stats();
    run_frame(3);
    cyc(0, 0, 0, 0);
    chk_frame("f_b2b_b", 0);

    // Rst together with Start mid-frame: reset wins, outputs cleared.
    clr_stats();
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 300; i++) cyc(0, 0, 1, $urandom);
    cyc(1, 1, 0, 0);
    chk("rststart_busy", Busy, 0);
    chk("rststart_done", Done, 0);
    chk("rststart_wren", Wr_En, 0);
    chk("rststart_addr", Wr_Addr, 0);
    chk("rststart_data", Wr_Data, 0);
    clr_stats();
    repeat (10) cyc(0, 0, 1, $urandom);
    chk("rststart_idle_nwr", n_wr, 0);
    chk("rststart_ndone", n_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
